// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache request/response and main-memory bus bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err;

  // Arbiter side: takes cache requests and memory completions, drives everything else
  modport master (
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output err
  );

  // Environment side: caches and main memory
  modport slave (
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialising data/instruction cache arbiter in front of main memory
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FAIRNESS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] FAIR_L  = 4'(FAIRNESS);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_gnt;    // arbitration decided, memory outputs load on the next edge
  logic              r_owner;  // 0 = data cache, 1 = instruction cache
  logic [3:0]        r_fcnt;
  logic [9:0]        r_wcnt;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_ready;
  logic              r_i_ready;
  logic              r_err;

  logic              w_d_pend;
  logic              w_i_pend;
  logic              w_pick_i;
  logic              w_sel_read;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_d_pend = bus.d_read | bus.d_write;
  assign w_i_pend = bus.i_read | bus.i_write;
  // Data wins unless the instruction side has waited through FAIRNESS data grants
  assign w_pick_i = w_i_pend & (~w_d_pend | (r_fcnt >= FAIR_L));

  assign w_sel_read  = r_owner ? bus.i_read  : bus.d_read;
  assign w_sel_write = r_owner ? bus.i_write : bus.d_write;
  assign w_sel_addr  = r_owner ? bus.i_addr  : bus.d_addr;
  assign w_sel_wdata = r_owner ? bus.i_wdata : bus.d_wdata;

  // Arbitration, memory sequencing, watchdog and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 1'b0;
      r_owner     <= 1'b0;
      r_fcnt      <= '0;
      r_wcnt      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_d_rdata   <= '0;
      r_i_rdata   <= '0;
      r_d_ready   <= 1'b0;
      r_i_ready   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_d_ready <= 1'b0;
      r_i_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_gnt) begin
            r_gnt       <= 1'b0;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_write <= w_sel_write;
            r_mem_read  <= w_sel_read & ~w_sel_write;
            r_wcnt      <= '0;
            r_state     <= ST_BUSY;
          end else if (w_d_pend | w_i_pend) begin
            r_gnt   <= 1'b1;
            r_owner <= w_pick_i;
            if (w_pick_i || !w_i_pend) begin
              r_fcnt <= '0;
            end else if (r_fcnt != 4'hF) begin
              r_fcnt <= r_fcnt + 4'd1;
            end
          end
        end
        ST_BUSY: begin
          if (bus.mem_ready) begin
            if (r_mem_read) begin
              if (r_owner) r_i_rdata <= bus.mem_rdata;
              else         r_d_rdata <= bus.mem_rdata;
            end
            r_d_ready   <= ~r_owner;
            r_i_ready   <= r_owner;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_wcnt == TO_LAST) begin
            if (r_owner) r_i_rdata <= '1;
            else         r_d_rdata <= '1;
            r_err       <= 1'b1;
            r_d_ready   <= ~r_owner;
            r_i_ready   <= r_owner;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_wcnt <= r_wcnt + 10'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_ready   = r_i_ready;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .FAIRNESS(4), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
  endtask

  task automatic do_reset;
    reset = 0;
    clear_inputs();
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if ({bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready, bus.err} !== 5'b0) begin
      n_bad++; $display("FAIL rst_ctrl: got %b expected 00000", {bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready, bus.err}); end
    n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_mem: got addr %h wdata %h expected 0", bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if (bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_rdata: got d %h i %h expected 0", bus.d_rdata, bus.i_rdata); end
    tick();
    n_cmp++; if ({bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready} !== 4'b0) begin
      n_bad++; $display("FAIL rst_idle: got %b expected 0000", {bus.mem_read, bus.mem_write, bus.d_ready, bus.i_ready}); end
  endtask

  task automatic test_single_read;
    do_reset();
    bus.d_read = 1; bus.d_addr = 32'h40;
    tick();
    n_cmp++; if (bus.mem_read !== 1'b0) begin
      n_bad++; $display("FAIL sr_early: got mem_read %b expected 0", bus.mem_read); end
    tick();
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h40) begin
      n_bad++; $display("FAIL sr_op: got rd %b wr %b addr %h expected 1 0 00000040", bus.mem_read, bus.mem_write, bus.mem_addr); end
    tick();
    tick();
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.d_ready !== 1'b0) begin
      n_bad++; $display("FAIL sr_hold: got rd %b d_ready %b expected 1 0", bus.mem_read, bus.d_ready); end
    bus.mem_rdata = 32'hDEADBEEF; bus.mem_ready = 1;
    tick();
    n_cmp++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0 || bus.d_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sr_resp: got d_ready %b i_ready %b d_rdata %h expected 1 0 deadbeef", bus.d_ready, bus.i_ready, bus.d_rdata); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin
      n_bad++; $display("FAIL sr_drop: got mem_read %b expected 0", bus.mem_read); end
    bus.mem_ready = 0; bus.d_read = 0;
    tick();
    n_cmp++; if (bus.d_ready !== 1'b0) begin
      n_bad++; $display("FAIL sr_pulse: got d_ready %b expected 0", bus.d_ready); end
  endtask

  task automatic test_simultaneous;
    int gap;
    do_reset();
    bus.d_read = 1; bus.d_addr = 32'h100;
    bus.i_read = 1; bus.i_addr = 32'h200;
    tick();
    tick();
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_bad++; $display("FAIL sim_first: got rd %b addr %h expected 1 00000100", bus.mem_read, bus.mem_addr); end
    bus.mem_rdata = 32'h11111111; bus.mem_ready = 1;
    tick();
    n_cmp++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0 || bus.d_rdata !== 32'h11111111) begin
      n_bad++; $display("FAIL sim_dresp: got d %b i %b d_rdata %h expected 1 0 11111111", bus.d_ready, bus.i_ready, bus.d_rdata); end
    bus.mem_ready = 0; bus.d_read = 0;
    gap = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.mem_read) begin gap = c; break; end
    end
    n_cmp++; if (gap !== 3) begin
      n_bad++; $display("FAIL sim_gap: got %0d cycles expected 3", gap); end
    n_cmp++; if (bus.mem_addr !== 32'h200) begin
      n_bad++; $display("FAIL sim_second: got addr %h expected 00000200", bus.mem_addr); end
    bus.mem_rdata = 32'h22222222; bus.mem_ready = 1;
    tick();
    n_cmp++; if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0 || bus.i_rdata !== 32'h22222222) begin
      n_bad++; $display("FAIL sim_iresp: got i %b d %b i_rdata %h expected 1 0 22222222", bus.i_ready, bus.d_ready, bus.i_rdata); end
    n_cmp++; if (bus.d_rdata !== 32'h11111111) begin
      n_bad++; $display("FAIL sim_dkeep: got d_rdata %h expected 11111111", bus.d_rdata); end
    bus.mem_ready = 0; bus.i_read = 0;
    tick();
    tick();
  endtask

  task automatic test_starvation;
    int  exp_i[6] = '{0, 0, 0, 0, 1, 0};
    bit  found;
    do_reset();
    bus.d_read = 1; bus.d_addr = 32'h1000;
    bus.i_read = 1; bus.i_addr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      found = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (bus.mem_read) begin found = 1; break; end
      end
      n_cmp++; if (found !== 1'b1) begin
        n_bad++; $display("FAIL starve_wait%0d: got no mem_read expected grant", k); end
      n_cmp++; if (bus.mem_addr !== (exp_i[k] != 0 ? 32'h2000 : 32'h1000)) begin
        n_bad++; $display("FAIL starve_grant%0d: got addr %h expected %h", k, bus.mem_addr, (exp_i[k] != 0 ? 32'h2000 : 32'h1000)); end
      bus.mem_rdata = 32'(k); bus.mem_ready = 1;
      tick();
      bus.mem_ready = 0;
      n_cmp++; if ({bus.d_ready, bus.i_ready} !== (exp_i[k] != 0 ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL starve_ready%0d: got d/i %b expected %b", k, {bus.d_ready, bus.i_ready}, (exp_i[k] != 0 ? 2'b01 : 2'b10)); end
      if (exp_i[k] != 0) bus.i_read = 0;
    end
    bus.d_read = 0;
    tick();
    tick();
  endtask

  task automatic test_write_priority;
    do_reset();
    bus.d_read = 1; bus.d_addr = 32'h80;
    tick();
    tick();
    bus.mem_rdata = 32'hA5A5A5A5; bus.mem_ready = 1;
    tick();
    bus.mem_ready = 0; bus.d_read = 0;
    tick();
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h84; bus.d_wdata = 32'h12345678;
    tick();
    tick();
    n_cmp++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wdata !== 32'h12345678 || bus.mem_addr !== 32'h84) begin
      n_bad++; $display("FAIL wr_op: got wr %b rd %b wdata %h addr %h expected 1 0 12345678 00000084", bus.mem_write, bus.mem_read, bus.mem_wdata, bus.mem_addr); end
    bus.d_addr = 32'hFF; bus.d_wdata = 32'h0;
    tick();
    n_cmp++; if (bus.mem_addr !== 32'h84 || bus.mem_wdata !== 32'h12345678) begin
      n_bad++; $display("FAIL wr_stable: got addr %h wdata %h expected 00000084 12345678", bus.mem_addr, bus.mem_wdata); end
    bus.mem_rdata = 32'h5A5A5A5A; bus.mem_ready = 1;
    tick();
    n_cmp++; if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'hA5A5A5A5 || bus.mem_write !== 1'b0) begin
      n_bad++; $display("FAIL wr_resp: got d_ready %b d_rdata %h mem_write %b expected 1 a5a5a5a5 0", bus.d_ready, bus.d_rdata, bus.mem_write); end
    bus.mem_ready = 0; bus.d_read = 0; bus.d_write = 0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    int hi;
    do_reset();
    bus.d_read = 1; bus.d_addr = 32'h300;
    tick();
    tick();
    hi = (bus.mem_read === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_read !== 1'b1) break;
      hi++;
    end
    n_cmp++; if (hi !== 8) begin
      n_bad++; $display("FAIL to_len: got %0d busy cycles expected 8", hi); end
    n_cmp++; if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'hFFFFFFFF || bus.err !== 1'b1) begin
      n_bad++; $display("FAIL to_abort: got d_ready %b d_rdata %h err %b expected 1 ffffffff 1", bus.d_ready, bus.d_rdata, bus.err); end
    bus.d_read = 0;
    repeat (5) tick();
    bus.i_read = 1; bus.i_addr = 32'h310;
    tick();
    tick();
    bus.mem_rdata = 32'h0BADF00D; bus.mem_ready = 1;
    tick();
    n_cmp++; if (bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h0BADF00D || bus.err !== 1'b1) begin
      n_bad++; $display("FAIL to_sticky: got i_ready %b i_rdata %h err %b expected 1 0badf00d 1", bus.i_ready, bus.i_rdata, bus.err); end
    bus.mem_ready = 0; bus.i_read = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    logic any_rdy;
    bus.d_read = 1; bus.d_addr = 32'h400;
    tick();
    tick();
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.err !== 1'b1) begin
      n_bad++; $display("FAIL rm_busy: got mem_read %b err %b expected 1 1", bus.mem_read, bus.err); end
    reset = 0; bus.d_read = 0;
    tick();
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++; $display("FAIL rm_abandon: got mem_read %b err %b expected 0 0", bus.mem_read, bus.err); end
    reset = 1; bus.mem_rdata = 32'h77777777; bus.mem_ready = 1;
    any_rdy = 0;
    repeat (3) begin
      tick();
      any_rdy = any_rdy | bus.d_ready | bus.i_ready | bus.mem_read;
    end
    bus.mem_ready = 0;
    n_cmp++; if (any_rdy !== 1'b0) begin
      n_bad++; $display("FAIL rm_late: got activity %b expected 0", any_rdy); end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin
      n_bad++; $display("FAIL rm_rdata: got d_rdata %h expected 00000000", bus.d_rdata); end
    bus.d_read = 1; bus.d_addr = 32'h404;
    tick();
    tick();
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h404) begin
      n_bad++; $display("FAIL rm_resume: got rd %b addr %h expected 1 00000404", bus.mem_read, bus.mem_addr); end
    bus.d_read = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_write_priority();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
